// File: rtl/drag_pkg.sv
// drag_pkg: shared engine types, widths and limits for the player engines
package drag_pkg;
  typedef enum logic [1:0] {IDLE, RACE, BLOWN} state_t;
  localparam int RPM_W = 8;
  localparam int GEAR_W = 3;
  localparam int DPOS_W = 5;
  localparam logic [RPM_W-1:0] RPM_MAX = 8'd255;
  localparam logic [GEAR_W-1:0] GEAR_MAX = 3'd5;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: one-clk enable strobe every TICK_DIV clocks; ports clk, i_clr (sync clear), o_tick (strobe)
module tick_gen #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic i_clr,
  output logic o_tick
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] r_cnt;
  assign o_tick = r_cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk) r_cnt <= (i_clr || o_tick) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/player2_engine.sv
// player2_engine: gas/shift to rpm, gear and per-tick position increment; ports clk, rst, reset_status, start, gas, shift_up -> d_position, gear, rpm, blown, racing
module player2_engine
  import drag_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000,
  parameter int RPM_UP = 4,
  parameter int RPM_DOWN = 2,
  parameter int OVERREV_TICKS = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reset_status,
  input  logic              start,
  input  logic              gas,
  input  logic              shift_up,
  output logic [DPOS_W-1:0] d_position,
  output logic [GEAR_W-1:0] gear,
  output logic [RPM_W-1:0]  rpm,
  output logic              blown,
  output logic              racing
);
  localparam int OW = $clog2(OVERREV_TICKS + 1);
  logic w_clr, w_tick, r_shift_q, r_edge;
  state_t r_state, w_state_n;
  logic [RPM_W-1:0] r_rpm, w_rpm_n, w_rpm_step;
  logic [RPM_W:0] w_up;
  logic [GEAR_W-1:0] r_gear, w_gear_n;
  logic [OW-1:0] r_ovr, w_ovr_n;
  logic [DPOS_W-1:0] r_dpos;
  logic [10:0] w_prod;
  assign w_clr = rst | reset_status;
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .i_clr(w_clr), .o_tick(w_tick));
  assign w_up = {1'b0, r_rpm} + (RPM_W + 1)'(RPM_UP);
  assign w_rpm_step = gas ? (w_up > {1'b0, RPM_MAX} ? RPM_MAX : w_up[RPM_W-1:0])
                          : (r_rpm < RPM_W'(RPM_DOWN) ? '0 : r_rpm - RPM_W'(RPM_DOWN));
  // Top 5 bits of the 11-bit product can never exceed 31, so the clamp is implicit
  assign w_prod = 11'(r_rpm) * 11'(r_gear);
  always_comb begin
    w_state_n = r_state;
    w_rpm_n = r_rpm;
    w_gear_n = r_gear;
    w_ovr_n = r_ovr;
    case (r_state)
      IDLE: begin
        w_rpm_n = w_tick ? w_rpm_step : r_rpm;
        w_state_n = start ? RACE : IDLE;
        w_gear_n = start ? GEAR_W'(1) : r_gear;
      end
      RACE: begin
        // an accepted shift swallows a coinciding tick entirely, over-rev included
        if (r_edge && r_gear < GEAR_MAX) begin
          w_gear_n = r_gear + 1'b1;
          w_rpm_n = r_rpm >> 1;
        end else if (w_tick) begin
          w_ovr_n = r_rpm == RPM_MAX ? r_ovr + 1'b1 : '0;
          w_state_n = w_ovr_n == OW'(OVERREV_TICKS) ? BLOWN : RACE;
          w_rpm_n = w_ovr_n == OW'(OVERREV_TICKS) ? '0 : w_rpm_step;
        end
      end
      default: w_rpm_n = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state <= IDLE;
      r_rpm <= '0;
      r_gear <= '0;
      r_ovr <= '0;
      r_shift_q <= 1'b0;
      r_edge <= 1'b0;
      r_dpos <= '0;
    end else begin
      r_state <= w_state_n;
      r_rpm <= w_rpm_n;
      r_gear <= w_gear_n;
      r_ovr <= w_ovr_n;
      r_shift_q <= shift_up;
      r_edge <= shift_up & ~r_shift_q;
      r_dpos <= w_prod[10:6];
    end
  end
  assign d_position = r_dpos;
  assign gear = r_gear;
  assign rpm = r_rpm;
  assign blown = r_state == BLOWN;
  assign racing = r_state == RACE;
endmodule

// File: doc/player2_engine.md
# player2_engine

Engine/gearbox model for player 2. Converts gas and shift-up button inputs into an RPM value and gear, and from those produces the per-tick position increment `d_position` that feeds player 2's position accumulator directly downstream. It runs entirely in the system clock domain and uses an internal tick strobe rather than a derived clock.

## Interface
Parameters:
- `TICK_DIV`, 1_000_000: system clocks per physics tick (100 Hz at 100 MHz).
- `RPM_UP`, 4: RPM added per tick while gas is held.
- `RPM_DOWN`, 2: RPM removed per tick while gas is released.
- `OVERREV_TICKS`, 200: consecutive ticks at RPM 255 before the engine blows.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `reset_status`  in  1  game restart; same effect as `rst`.
- `start`  in  1  race-go level.
- `gas`  in  1  throttle held, debounced externally.
- `shift_up`  in  1  shift button, debounced level; rising edge detected internally.
- `d_position`  out  5  position increment per tick, registered.
- `gear`  out  3  0 = neutral, 1..5.
- `rpm`  out  8  engine RPM / 32 scale.
- `blown`  out  1  engine destroyed.
- `racing`  out  1  high in RACE.

## Operation
- The tick strobe is high for one `clk` every `TICK_DIV` cycles. Its counter clears on `rst` or `reset_status`.
- FSM states: IDLE, RACE, BLOWN.
  - IDLE: gear = 0, `d_position` = 0. RPM updates on each tick (revving in neutral is allowed). On `start`=1, the FSM goes to RACE and gear becomes 1. RPM is kept.
  - RACE: on each tick, RPM becomes `min(rpm+RPM_UP, 255)` if `gas`, else `max(rpm-RPM_DOWN, 0)`.
  - Shift in RACE: a rising edge of `shift_up` with gear < 5 sets gear+1 and RPM = RPM>>1. The shift applies on the cycle after the edge is detected. At gear 5 the shift is ignored.
  - Shift in IDLE or BLOWN: ignored.
  - Shift on the same cycle as a tick: the shift wins and that tick's RPM update is dropped.
  - Over-rev: a counter increments on each RACE tick with RPM = 255 and clears on any tick with RPM < 255. When it reaches `OVERREV_TICKS`, the FSM goes to BLOWN.
  - BLOWN: RPM forced to 0, gear held, `blown`=1, `d_position`=0. BLOWN exits only via `rst` or `reset_status`.
- `rst` or `reset_status` from any state: IDLE, RPM 0, gear 0, over-rev counter 0, edge-detector history 0.
- Output arithmetic: `d_position = (rpm * gear) >> 6`. The product is 11 bits wide; the result is clamped to 31. The maximum reachable value is 19 (255×5>>6).

## Timing
- Reset values: `d_position`=0, `gear`=0, `rpm`=0, `blown`=0, `racing`=0.
- `d_position` updates 1 clk after an RPM or gear change.
- `rpm`, `gear`, `blown` and `racing` are registered and update on the clk edge where the state or tick takes effect.
- `shift_up` edge to new gear: 2 clk (1 clk edge register, 1 clk update).
- `start` to `racing`=1: 1 clk.
- `reset_status` takes effect on the next clk edge and overrides every other input that cycle.
- A held `shift_up` produces exactly one shift.

## Structure
- Package `drag_pkg`: FSM state enum (IDLE/RACE/BLOWN), `GEAR_MAX`=5, `RPM_MAX`=255, RPM and `d_position` widths.
- Sub-module `tick_gen`, parameterised by `TICK_DIV`: counter plus single-cycle enable strobe, with synchronous clear. The same module is reused by the player 1 engine.

## Test plan
All scenarios run with `TICK_DIV`=4.
- Reset/IDLE: assert `rst`, then gas for 10 ticks without `start` → RPM=40, gear=0, `d_position`=0, `racing`=0.
- Launch: `start`, gas held for 64 ticks → gear 1, RPM=255 (saturated), `d_position`=3.
- Shift: at RPM=200 in gear 1, pulse `shift_up` → 2 clk later gear=2, RPM=100, then `d_position`=3. Holding `shift_up` high gives exactly one shift.
- Gear limit and coincidence: at gear 5, `shift_up` is ignored. A shift edge on the same cycle as a tick gives RPM halved with no `RPM_UP` added.
- Over-rev: `OVERREV_TICKS`=5, gas held at 255 → on the 5th tick `blown`=1, RPM=0, `d_position`=0. Releasing gas at tick 3 instead clears the counter and the engine is not blown.
- Mid-race restart: `reset_status` pulse in RACE gear 3 → next clk all outputs return to reset values and the tick counter restarts.
